// File: rtl/rc4_stream_encryptor.sv
// RC4 encryptor: S init, key schedule and keystream XOR in one FSM over a shared S RAM.
// The S bus is driven to all zeros whenever the FSM is idle, so it can be OR-muxed with other masters.
module rc4_stream_encryptor #(
    parameter int MSG_LEN = 32,
    parameter int KEY_LEN = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [23:0] secret_key,
    output logic [7:0]  s_address,
    output logic [7:0]  s_data,
    output logic        s_wren,
    input  logic [7:0]  s_q,
    output logic [7:0]  p_address,
    input  logic [7:0]  p_q,
    output logic [7:0]  c_address,
    output logic [7:0]  c_data,
    output logic        c_wren,
    output logic        busy,
    output logic        done
);

    typedef enum logic [3:0] {
        ST_IDLE, ST_INIT, ST_RD_I, ST_CAP_I, ST_RD_J, ST_CAP_J,
        ST_WR_I, ST_WR_J, ST_RD_F, ST_CAP_F, ST_WR_C, ST_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  s_address_q, s_address_d, s_data_q, s_data_d;
    logic        s_wren_q, s_wren_d;
    logic [7:0]  p_address_q, p_address_d;
    logic [7:0]  c_address_q, c_address_d, c_data_q, c_data_d;
    logic        c_wren_q, c_wren_d, busy_q, busy_d, done_q, done_d;
    logic [7:0]  i_q, i_d, j_q, j_d, si_q, si_d, sj_q, sj_d, pbyte_q, pbyte_d;
    logic [23:0] key_q, key_d;
    logic [1:0]  kidx_q, kidx_d;
    logic [8:0]  k_q, k_d;
    logic        prga_q, prga_d;
    logic [7:0]  j_next;

    function automatic logic [7:0] key_byte(input logic [23:0] key, input logic [1:0] idx);
        return 8'(key >> (8 * (KEY_LEN - 1 - int'(idx))));
    endfunction

    always_comb begin
        state_d     = state_q;
        s_address_d = s_address_q;
        s_data_d    = s_data_q;
        s_wren_d    = 1'b0;
        p_address_d = p_address_q;
        c_address_d = c_address_q;
        c_data_d    = c_data_q;
        c_wren_d    = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        i_d         = i_q;
        j_d         = j_q;
        si_d        = si_q;
        sj_d        = sj_q;
        pbyte_d     = pbyte_q;
        key_d       = key_q;
        kidx_d      = kidx_q;
        k_d         = k_q;
        prga_d      = prga_q;
        j_next      = prga_q ? 8'(j_q + s_q) : 8'(j_q + s_q + key_byte(key_q, kidx_q));

        case (state_q)
            ST_IDLE: begin
                s_address_d = 8'd0;
                s_data_d    = 8'd0;
                p_address_d = 8'd0;
                c_address_d = 8'd0;
                c_data_d    = 8'd0;
                busy_d      = 1'b0;
                if (start) begin
                    key_d    = secret_key;
                    i_d      = 8'd0;
                    j_d      = 8'd0;
                    busy_d   = 1'b1;
                    s_wren_d = 1'b1;
                    state_d  = ST_INIT;
                end
            end
            ST_INIT: begin
                if (i_q == 8'd255) begin
                    i_d         = 8'd0;
                    j_d         = 8'd0;
                    kidx_d      = 2'd0;
                    prga_d      = 1'b0;
                    s_address_d = 8'd0;
                    state_d     = ST_RD_I;
                end else begin
                    i_d         = i_q + 8'd1;
                    s_address_d = i_q + 8'd1;
                    s_data_d    = i_q + 8'd1;
                    s_wren_d    = 1'b1;
                end
            end
            ST_RD_I: state_d = ST_CAP_I;
            ST_CAP_I: begin
                // Plaintext was addressed together with S[i], so p_q is valid here too.
                si_d        = s_q;
                pbyte_d     = p_q;
                j_d         = j_next;
                s_address_d = j_next;
                if (!prga_q)
                    kidx_d = (kidx_q == 2'(KEY_LEN - 1)) ? 2'd0 : kidx_q + 2'd1;
                state_d     = ST_RD_J;
            end
            ST_RD_J: state_d = ST_CAP_J;
            ST_CAP_J: begin
                sj_d        = s_q;
                s_address_d = i_q;
                s_data_d    = s_q;
                s_wren_d    = 1'b1;
                state_d     = ST_WR_I;
            end
            ST_WR_I: begin
                s_address_d = j_q;
                s_data_d    = si_q;
                s_wren_d    = 1'b1;
                state_d     = ST_WR_J;
            end
            ST_WR_J: begin
                if (prga_q) begin
                    s_address_d = 8'(si_q + sj_q);
                    state_d     = ST_RD_F;
                end else if (i_q == 8'd255) begin
                    prga_d      = 1'b1;
                    i_d         = 8'd1;
                    j_d         = 8'd0;
                    k_d         = 9'd0;
                    s_address_d = 8'd1;
                    p_address_d = 8'd0;
                    state_d     = ST_RD_I;
                end else begin
                    i_d         = i_q + 8'd1;
                    s_address_d = i_q + 8'd1;
                    state_d     = ST_RD_I;
                end
            end
            ST_RD_F: state_d = ST_CAP_F;
            ST_CAP_F: begin
                c_address_d = k_q[7:0];
                c_data_d    = s_q ^ pbyte_q;
                c_wren_d    = 1'b1;
                state_d     = ST_WR_C;
            end
            ST_WR_C: begin
                if (k_q == 9'(MSG_LEN - 1)) begin
                    s_address_d = 8'd0;
                    s_data_d    = 8'd0;
                    p_address_d = 8'd0;
                    c_address_d = 8'd0;
                    c_data_d    = 8'd0;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    k_d         = k_q + 9'd1;
                    i_d         = i_q + 8'd1;
                    s_address_d = i_q + 8'd1;
                    p_address_d = k_q[7:0] + 8'd1;
                    state_d     = ST_RD_I;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            s_address_q <= 8'd0;
            s_data_q    <= 8'd0;
            s_wren_q    <= 1'b0;
            p_address_q <= 8'd0;
            c_address_q <= 8'd0;
            c_data_q    <= 8'd0;
            c_wren_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            i_q         <= 8'd0;
            j_q         <= 8'd0;
            kidx_q      <= 2'd0;
            k_q         <= 9'd0;
            prga_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_address_q <= s_address_d;
            s_data_q    <= s_data_d;
            s_wren_q    <= s_wren_d;
            p_address_q <= p_address_d;
            c_address_q <= c_address_d;
            c_data_q    <= c_data_d;
            c_wren_q    <= c_wren_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            i_q         <= i_d;
            j_q         <= j_d;
            si_q        <= si_d;
            sj_q        <= sj_d;
            pbyte_q     <= pbyte_d;
            key_q       <= key_d;
            kidx_q      <= kidx_d;
            k_q         <= k_d;
            prga_q      <= prga_d;
        end
    end

    assign s_address = s_address_q;
    assign s_data    = s_data_q;
    assign s_wren    = s_wren_q;
    assign p_address = p_address_q;
    assign c_address = c_address_q;
    assign c_data    = c_data_q;
    assign c_wren    = c_wren_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_rc4_stream_encryptor.sv
// Bench for rc4_stream_encryptor with 9-byte messages: S, plaintext and ciphertext memories
// are modelled as 1-cycle synchronous RAMs around the DUT.
module tb_rc4_stream_encryptor;
    localparam int MSG_LEN = 9;
    localparam int LAT_MAX = 256 + 256 * 8 + MSG_LEN * 12;
    localparam int TIMEOUT = 4000;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [23:0] secret_key;
    logic [7:0]  s_address, s_data, s_q, p_address, p_q, c_address, c_data;
    logic        s_wren, c_wren, busy, done;

    rc4_stream_encryptor #(.MSG_LEN(MSG_LEN), .KEY_LEN(3)) dut (
        .clk(clk), .reset(reset), .start(start), .secret_key(secret_key),
        .s_address(s_address), .s_data(s_data), .s_wren(s_wren), .s_q(s_q),
        .p_address(p_address), .p_q(p_q),
        .c_address(c_address), .c_data(c_data), .c_wren(c_wren),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [7:0] smem [256];
    logic [7:0] pmem [256];
    logic [7:0] cmem [256];
    logic [7:0] mS   [256];
    logic       clr_c = 1'b0;

    always @(posedge clk) begin
        if (s_wren) smem[s_address] <= s_data;
        s_q <= smem[s_address];
        p_q <= pmem[p_address];
        if (clr_c) begin
            for (int n = 0; n < 256; n++) cmem[n] <= 8'h5A;
        end else if (c_wren) begin
            cmem[c_address] <= c_data;
        end
    end

    int cw_total = 0, done_total = 0, both_total = 0;
    always @(negedge clk) begin
        if (c_wren) cw_total++;
        if (done) done_total++;
        if (s_wren && c_wren) both_total++;
    end

    int n_tests = 0, n_fail = 0;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic all_zero();
        return (s_address == 8'd0) && (s_data == 8'd0) && !s_wren && (p_address == 8'd0) &&
               (c_address == 8'd0) && (c_data == 8'd0) && !c_wren && !busy && !done;
    endfunction

    // Straight software RC4 over a 3-byte key; leaves the final S state in mS.
    task automatic model_rc4(input logic [23:0] key, input logic [71:0] pt, output logic [71:0] ct);
        logic [7:0] i, j, t, f;
        for (int n = 0; n < 256; n++) mS[n] = 8'(n);
        j = 8'd0;
        for (int n = 0; n < 256; n++) begin
            j = j + mS[n] + key[23 - 8 * (n % 3) -: 8];
            t = mS[n]; mS[n] = mS[j]; mS[j] = t;
        end
        i = 8'd0; j = 8'd0; ct = '0;
        for (int k = 0; k < MSG_LEN; k++) begin
            i = i + 8'd1;
            j = j + mS[i];
            t = mS[i]; mS[i] = mS[j]; mS[j] = t;
            f = mS[i] + mS[j];
            ct[71 - 8 * k -: 8] = pt[71 - 8 * k -: 8] ^ mS[f];
        end
    endtask

    typedef struct {
        string       name;
        logic [23:0] key;
        logic [71:0] pt;
        logic [71:0] ct;
        bit          from_model;
    } vec_t;

    vec_t vecs[7];

    task automatic run_and_check(input vec_t v, input int inject_at);
        int          lat, cw0, d0, nbad;
        bit          timed_out, busy_low;
        logic [71:0] got, mct;
        for (int n = 0; n < 256; n++) pmem[n] = (n < MSG_LEN) ? v.pt[71 - 8 * n -: 8] : 8'h00;
        clr_c = 1'b1;
        @(negedge clk);
        clr_c = 1'b0;
        cw0 = cw_total; d0 = done_total;
        start = 1'b1; secret_key = v.key;
        @(negedge clk);
        start = 1'b0;
        lat = 0; timed_out = 1'b1; busy_low = 1'b0;
        while (lat < TIMEOUT) begin
            start = (lat == inject_at);
            if (start) secret_key = 24'hFFFFFF;
            @(negedge clk);
            lat++;
            if (done) begin
                timed_out = 1'b0;
                break;
            end
            if (!busy) busy_low = 1'b1;
        end
        start = 1'b0;
        check({v.name, " timeout"}, 72'(timed_out), 72'd0);
        repeat (3) @(negedge clk);
        for (int n = 0; n < MSG_LEN; n++) got[71 - 8 * n -: 8] = cmem[n];
        check({v.name, " ciphertext"}, got, v.ct);
        check({v.name, " done pulses"}, 72'(done_total - d0), 72'd1);
        check({v.name, " c_wren cycles"}, 72'(cw_total - cw0), 72'(MSG_LEN));
        check({v.name, " busy after done"}, 72'(busy), 72'd0);
        check({v.name, " busy dropped early"}, 72'(busy_low), 72'd0);
        check({v.name, " latency within bound"}, 72'(lat <= LAT_MAX), 72'd1);
        model_rc4(v.key, v.pt, mct);
        nbad = 0;
        for (int n = 0; n < 256; n++) if (smem[n] !== mS[n]) nbad++;
        check({v.name, " final S mismatches"}, 72'(nbad), 72'd0);
    endtask

    initial begin
        int          bad, cw0, d0;
        logic [71:0] tmp;
        reset = 1'b1; start = 1'b0; secret_key = 24'd0;
        for (int n = 0; n < 256; n++) pmem[n] = 8'h00;
        repeat (3) @(negedge clk);
        check("reset state outputs zero", 72'(all_zero()), 72'd1);
        reset = 1'b0;

        bad = 0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (!all_zero()) bad++;
        end
        check("idle bus release cycles nonzero", 72'(bad), 72'd0);

        vecs[0] = '{"known Key/Plaintext", 24'h4B6579, 72'h506C61696E74657874, 72'hBBF316E8D940AF0AD3, 1'b0};
        vecs[1] = '{"known decrypt",       24'h4B6579, 72'hBBF316E8D940AF0AD3, 72'h506C61696E74657874, 1'b0};
        vecs[2] = '{"known keystream",     24'h4B6579, 72'h0,                  72'hEB9F7781B734CA72A7, 1'b0};
        vecs[3] = '{"key FFFFFF",          24'hFFFFFF, 72'h616263646566676869, 72'h0, 1'b1};
        vecs[4] = '{"key 000000",          24'h000000, {9{8'hFF}},             72'h0, 1'b1};
        vecs[5] = '{"key 00035F encrypt",  24'h00035F, 72'h726F756E6474726970, 72'h0, 1'b1};
        for (int v = 0; v < 6; v++)
            if (vecs[v].from_model) begin
                model_rc4(vecs[v].key, vecs[v].pt, tmp);
                vecs[v].ct = tmp;
            end
        vecs[6] = '{"key 00035F round trip", 24'h00035F, vecs[5].ct, 72'h726F756E6474726970, 1'b0};

        for (int v = 0; v < 7; v++) run_and_check(vecs[v], -1);

        // Abort in the middle of the key schedule, around i=100.
        for (int n = 0; n < MSG_LEN; n++) pmem[n] = vecs[0].pt[71 - 8 * n -: 8];
        start = 1'b1; secret_key = 24'h4B6579;
        @(negedge clk);
        start = 1'b0;
        repeat (256 + 6 * 100 + 1) @(negedge clk);
        check("busy before mid-KSA reset", 72'(busy), 72'd1);
        cw0 = cw_total; d0 = done_total;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("outputs zero after mid-KSA reset", 72'(all_zero()), 72'd1);
        bad = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (!all_zero()) bad++;
        end
        bad += (cw_total - cw0) + (done_total - d0);
        check("idle after mid-KSA reset", 72'(bad), 72'd0);
        run_and_check(vecs[0], -1);

        // A second start with a different key during keystream generation must be ignored.
        vecs[0].name = "start while busy";
        run_and_check(vecs[0], 1800);

        check("cycles with s_wren and c_wren", 72'(both_total), 72'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
